// File: rtl/bus_pkg.sv
// Shared types and constants for the bus cycle controller:
// FSM states, chip-select indices, I/O page bases and the wait-count type.
package bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_XFER = 3'd3,
    S_HOLD = 3'd4
  } bus_state_e;

  localparam int CS_MEM_LO = 0;
  localparam int CS_MEM_HI = 1;
  localparam int CS_IO_A   = 2;
  localparam int CS_IO_B   = 3;

  localparam logic [11:0] IO_A_BASE = 12'hFF0;
  localparam logic [11:0] IO_B_BASE = 12'h1C0;

  typedef logic [2:0] wait_cnt_t;

  // Debug view of the controller's internal state.
  typedef struct packed {
    bus_state_e  state;
    wait_cnt_t   wait_cnt;
    logic        iom;
    logic [19:0] addr;
  } bus_dbg_t;

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// CPU-side bus signals of the cycle controller.
// The CPU (master) drives ALE/IOM/RD/WR/ADDRESS; the controller (slave) drives
// CS/LOAD/OE/WE/READY/ERR. RD and WR are active-low strobes; READY low = wait.
interface bus_cycle_ctrl_if;
  logic        ALE;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic [19:0] ADDRESS;
  logic [3:0]  CS;
  logic        LOAD;
  logic        OE;
  logic        WE;
  logic        READY;
  logic        ERR;

  modport master (
    output ALE, IOM, RD, WR, ADDRESS,
    input  CS, LOAD, OE, WE, READY, ERR
  );

  modport slave (
    input  ALE, IOM, RD, WR, ADDRESS,
    output CS, LOAD, OE, WE, READY, ERR
  );
endinterface

// File: rtl/addr_decode.sv
// Combinational region decode of the captured address/IOM into a one-hot
// device select; an I/O address outside both known pages is a miss.
module addr_decode
  import bus_pkg::*;
(
  input  logic        a19,
  input  logic [11:0] io_page,
  input  logic        iom,
  output logic [3:0]  cs,
  output logic        miss
);

  always_comb begin
    cs   = 4'b0000;
    miss = 1'b0;
    if (!iom) begin
      if (a19) cs[CS_MEM_HI] = 1'b1;
      else     cs[CS_MEM_LO] = 1'b1;
    end else if (io_page == IO_A_BASE) begin
      cs[CS_IO_A] = 1'b1;
    end else if (io_page == IO_B_BASE) begin
      cs[CS_IO_B] = 1'b1;
    end else begin
      miss = 1'b1;
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: latches the address on ALE, decodes a device select,
// inserts per-region wait states and generates OE/WE/READY/ERR.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int WAIT_MEM0 = 0,
  parameter int WAIT_MEM1 = 1,
  parameter int WAIT_IO   = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  bus_cycle_ctrl_if.slave        bus,
  output bus_dbg_t               dbg
);

  bus_state_e  state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic        iom_q, iom_d;
  wait_cnt_t   cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        is_wr_q, is_wr_d;
  logic        proto_q, proto_d;

  logic [3:0]  dec_cs;
  logic        dec_miss;
  wait_cnt_t   region_wait;
  logic        active, both_low, one_low;
  logic [3:0]  cs;
  logic        load, oe, we, ready;

  addr_decode u_addr_decode (
    .a19     (addr_q[19]),
    .io_page (addr_q[15:4]),
    .iom     (iom_q),
    .cs      (dec_cs),
    .miss    (dec_miss)
  );

  assign active   = (state_q != S_IDLE);
  assign both_low = ~bus.RD & ~bus.WR;
  assign one_low  = bus.RD ^ bus.WR;

  always_comb begin
    region_wait = 3'd0;
    if (dec_miss)       region_wait = 3'd0;
    else if (iom_q)     region_wait = wait_cnt_t'(WAIT_IO);
    else if (addr_q[19]) region_wait = wait_cnt_t'(WAIT_MEM1);
    else                region_wait = wait_cnt_t'(WAIT_MEM0);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    iom_d   = iom_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    is_wr_d = is_wr_q;
    proto_d = proto_q;
    cs      = active ? dec_cs : 4'b0000;
    load    = 1'b0;
    oe      = 1'b0;
    we      = 1'b0;
    ready   = (state_q != S_WAIT);

    if (active && dec_miss) err_d = 1'b1;

    if (bus.ALE) begin
      // A new ALE always starts a fresh cycle, aborting any cycle in flight.
      addr_d  = bus.ADDRESS;
      iom_d   = bus.IOM;
      load    = 1'b1;
      proto_d = 1'b0;
      state_d = S_ADDR;
    end else if (active && (both_low || proto_q)) begin
      // Both strobes low: freeze here until both are released, then abandon.
      if (both_low) err_d = 1'b1;
      proto_d = 1'b1;
      if (bus.RD && bus.WR) begin
        proto_d = 1'b0;
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ADDR: begin
          if (one_low) begin
            cnt_d   = region_wait;
            is_wr_d = ~bus.WR;
            state_d = (region_wait != 3'd0) ? S_WAIT : S_XFER;
          end
        end
        S_WAIT: begin
          if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = S_XFER;
        end
        S_XFER: begin
          oe      = ~bus.RD & ~dec_miss;
          we      = is_wr_q & ~dec_miss;
          state_d = S_HOLD;
        end
        S_HOLD: begin
          oe = ~bus.RD & ~dec_miss;
          if (bus.RD && bus.WR) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Reset wins over everything, including strobes in flight.
    if (RESET) begin
      cs    = 4'b0000;
      load  = 1'b0;
      oe    = 1'b0;
      we    = 1'b0;
      ready = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      addr_q  <= 20'h0;
      iom_q   <= 1'b0;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
      is_wr_q <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      iom_q   <= iom_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      is_wr_q <= is_wr_d;
      proto_q <= proto_d;
    end
  end

  assign bus.CS    = cs;
  assign bus.LOAD  = load;
  assign bus.OE    = oe;
  assign bus.WE    = we;
  assign bus.READY = ready;
  assign bus.ERR   = err_q;

  assign dbg = '{state: state_q, wait_cnt: cnt_q, iom: iom_q, addr: addr_q};

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: memory/I-O cycles, wait states, decode
// miss, abort on ALE, reset mid-cycle and the both-strobes protocol error.
module tb_bus_cycle_ctrl;
  import bus_pkg::*;

  logic     CLK = 1'b0;
  logic     RESET = 1'b1;
  bus_dbg_t dbg;
  int       n_tests = 0;
  int       n_fail = 0;

  always #5 CLK = ~CLK;

  bus_cycle_ctrl_if bus ();

  bus_cycle_ctrl #(
    .WAIT_MEM0 (0),
    .WAIT_MEM1 (1),
    .WAIT_IO   (2)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .dbg   (dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [3:0] cs, input logic load,
                      input logic oe, input logic we, input logic ready, input logic err);
    chk({tag, ".cs"},    32'(bus.CS),    32'(cs));
    chk({tag, ".load"},  32'(bus.LOAD),  32'(load));
    chk({tag, ".oe"},    32'(bus.OE),    32'(oe));
    chk({tag, ".we"},    32'(bus.WE),    32'(we));
    chk({tag, ".ready"}, 32'(bus.READY), 32'(ready));
    chk({tag, ".err"},   32'(bus.ERR),   32'(err));
  endtask

  task automatic st(input string tag, input bus_state_e s);
    chk({tag, ".state"}, 32'(dbg.state), 32'(s));
  endtask

  // Inputs change just after a rising edge; checks happen before the falling edge.
  task automatic drive(input logic ale, input logic iom, input logic rd,
                       input logic wr, input logic [19:0] addr);
    bus.ALE     = ale;
    bus.IOM     = iom;
    bus.RD      = rd;
    bus.WR      = wr;
    bus.ADDRESS = addr;
    #2;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset
    drive(0, 0, 1, 1, 20'h0);
    cyc(); cyc();
    RESET = 1'b0;
    drive(0, 0, 1, 1, 20'h0);
    outs("rst", 4'b0000, 0, 0, 0, 1, 0);
    st("rst", S_IDLE);
    chk("rst.addr", 32'(dbg.addr), 32'h0);
    chk("rst.cnt",  32'(dbg.wait_cnt), 32'h0);

    // Memory read, region 0, no waits
    cyc(); drive(1, 0, 1, 1, 20'h00100);
    outs("mr_ale", 4'b0000, 1, 0, 0, 1, 0);
    st("mr_ale", S_IDLE);
    cyc(); drive(0, 0, 0, 1, 20'h0);
    st("mr_addr", S_ADDR);
    outs("mr_addr", 4'b0001, 0, 0, 0, 1, 0);
    chk("mr_addr.cap", 32'(dbg.addr), 32'h00100);
    cyc(); drive(0, 0, 0, 1, 20'h0);
    st("mr_xfer", S_XFER);
    outs("mr_xfer", 4'b0001, 0, 1, 0, 1, 0);
    cyc(); drive(0, 0, 0, 1, 20'h0);
    st("mr_hold", S_HOLD);
    outs("mr_hold", 4'b0001, 0, 1, 0, 1, 0);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("mr_rel", S_HOLD);
    outs("mr_rel", 4'b0001, 0, 0, 0, 1, 0);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("mr_idle", S_IDLE);
    outs("mr_idle", 4'b0000, 0, 0, 0, 1, 0);

    // Memory write, region 1, one wait state
    cyc(); drive(1, 0, 1, 1, 20'h80010);
    outs("mw_ale", 4'b0000, 1, 0, 0, 1, 0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    st("mw_addr", S_ADDR);
    outs("mw_addr", 4'b0010, 0, 0, 0, 1, 0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    st("mw_wait", S_WAIT);
    outs("mw_wait", 4'b0010, 0, 0, 0, 0, 0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    st("mw_xfer", S_XFER);
    outs("mw_xfer", 4'b0010, 0, 0, 1, 1, 0);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("mw_hold", S_HOLD);
    outs("mw_hold", 4'b0010, 0, 0, 0, 1, 0);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("mw_idle", S_IDLE);
    outs("mw_idle", 4'b0000, 0, 0, 0, 1, 0);

    // I/O read, page A, two wait states
    cyc(); drive(1, 1, 1, 1, 20'h0FF04);
    outs("ior_ale", 4'b0000, 1, 0, 0, 1, 0);
    cyc(); drive(0, 0, 0, 1, 20'h0);
    st("ior_addr", S_ADDR);
    outs("ior_addr", 4'b0100, 0, 0, 0, 1, 0);
    cyc(); drive(0, 0, 0, 1, 20'h0);
    st("ior_w1", S_WAIT);
    outs("ior_w1", 4'b0100, 0, 0, 0, 0, 0);
    chk("ior_w1.cnt", 32'(dbg.wait_cnt), 32'd2);
    cyc(); drive(0, 0, 0, 1, 20'h0);
    st("ior_w2", S_WAIT);
    outs("ior_w2", 4'b0100, 0, 0, 0, 0, 0);
    chk("ior_w2.cnt", 32'(dbg.wait_cnt), 32'd1);
    cyc(); drive(0, 0, 0, 1, 20'h0);
    st("ior_xfer", S_XFER);
    outs("ior_xfer", 4'b0100, 0, 1, 0, 1, 0);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("ior_idle", S_IDLE);

    // I/O write, page B (upper address bits ignored for I/O)
    cyc(); drive(1, 1, 1, 1, 20'h31C0A);
    outs("iow_ale", 4'b0000, 1, 0, 0, 1, 0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    outs("iow_addr", 4'b1000, 0, 0, 0, 1, 0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    st("iow_xfer", S_XFER);
    outs("iow_xfer", 4'b1000, 0, 0, 1, 1, 0);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("iow_idle", S_IDLE);

    // Decode miss: no select, no WE, no waits, sticky ERR
    cyc(); drive(1, 1, 1, 1, 20'h01230);
    outs("miss_ale", 4'b0000, 1, 0, 0, 1, 0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    st("miss_addr", S_ADDR);
    outs("miss_addr", 4'b0000, 0, 0, 0, 1, 0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    st("miss_xfer", S_XFER);
    outs("miss_xfer", 4'b0000, 0, 0, 0, 1, 1);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("miss_hold", S_HOLD);
    outs("miss_hold", 4'b0000, 0, 0, 0, 1, 1);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("miss_idle", S_IDLE);
    outs("miss_idle", 4'b0000, 0, 0, 0, 1, 1);

    // Abort during WAIT, then reset during XFER of the new cycle
    cyc(); drive(1, 1, 1, 1, 20'h0FF04);
    outs("ab_ale", 4'b0000, 1, 0, 0, 1, 1);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    outs("ab_addr", 4'b0100, 0, 0, 0, 1, 1);
    cyc(); drive(1, 0, 1, 1, 20'h80020);
    st("ab_wait", S_WAIT);
    outs("ab_wait", 4'b0100, 1, 0, 0, 0, 1);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    st("ab_addr2", S_ADDR);
    chk("ab_addr2.cap", 32'(dbg.addr), 32'h80020);
    outs("ab_addr2", 4'b0010, 0, 0, 0, 1, 1);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    st("ab_wait2", S_WAIT);
    outs("ab_wait2", 4'b0010, 0, 0, 0, 0, 1);
    cyc();
    RESET = 1'b1;
    drive(0, 0, 1, 0, 20'h0);
    st("rx_xfer", S_XFER);
    outs("rx_xfer", 4'b0000, 0, 0, 0, 1, 1);
    cyc();
    RESET = 1'b0;
    drive(0, 0, 1, 1, 20'h0);
    st("rx_done", S_IDLE);
    outs("rx_done", 4'b0000, 0, 0, 0, 1, 0);
    chk("rx_done.addr", 32'(dbg.addr), 32'h0);
    chk("rx_done.cnt",  32'(dbg.wait_cnt), 32'h0);

    // Protocol error: both strobes low in ADDR
    cyc(); drive(1, 0, 1, 1, 20'h00200);
    outs("pe_ale", 4'b0000, 1, 0, 0, 1, 0);
    cyc(); drive(0, 0, 0, 0, 20'h0);
    st("pe_both", S_ADDR);
    outs("pe_both", 4'b0001, 0, 0, 0, 1, 0);
    cyc(); drive(0, 0, 1, 0, 20'h0);
    st("pe_hold", S_ADDR);
    outs("pe_hold", 4'b0001, 0, 0, 0, 1, 1);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("pe_hold2", S_ADDR);
    outs("pe_hold2", 4'b0001, 0, 0, 0, 1, 1);
    cyc(); drive(0, 0, 1, 1, 20'h0);
    st("pe_idle", S_IDLE);
    outs("pe_idle", 4'b0000, 0, 0, 0, 1, 1);

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 Parameter WAIT_MEM0, default 0, wait states inserted for memory region 0 (0-7).
REQ-002 Parameter WAIT_MEM1, default 1, wait states inserted for memory region 1 (0-7).
REQ-003 Parameter WAIT_IO, default 2, wait states inserted for both I/O regions (0-7).
REQ-004 CLK  in  1  bus clock; all state changes on its rising edge.
REQ-005 RESET  in  1  reset, synchronous, active-high.
REQ-006 ALE  in  1  address latch enable, active-high, one CLK wide per bus cycle.
REQ-007 IOM  in  1  1 = I/O cycle, 0 = memory cycle; sampled with ALE.
REQ-008 RD  in  1  read strobe, active-low.
REQ-009 WR  in  1  write strobe, active-low.
REQ-010 ADDRESS  in  20  demultiplexed address; valid while ALE is high.
REQ-011 CS  out  4  one-hot device selects: [0] mem lo, [1] mem hi, [2] I/O A, [3] I/O B.
REQ-012 LOAD  out  1  one-CLK pulse telling the selected device to latch its address.
REQ-013 OE  out  1  read-data output enable to the selected device.
REQ-014 WE  out  1  one-CLK write pulse to the selected device.
REQ-015 READY  out  1  high = CPU may complete; low = wait state.
REQ-016 ERR  out  1  sticky decode or protocol error flag.

Function
REQ-017 States: IDLE, ADDR, WAIT, XFER, HOLD.
REQ-018 IDLE: ALE=1 captures ADDRESS and IOM into internal registers, asserts LOAD for that one cycle, and moves to ADDR.
REQ-019 Decode, from captured values: IOM=0 & A19=0 -> CS[0]; IOM=0 & A19=1 -> CS[1]; IOM=1 & A[15:4]=12'hFF0 -> CS[2]; IOM=1 & A[15:4]=12'h1C0 -> CS[3]; any other I/O address -> no CS (miss).
REQ-020 CS is driven from the cycle after capture until return to IDLE; at most one bit is ever set.
REQ-021 ADDR: RD=0 or WR=0 (exactly one low) loads the wait counter with the region's wait count; the FSM goes to WAIT if the count is nonzero, else to XFER.
REQ-022 WAIT: READY=0; the counter decrements each cycle; at count 1 the FSM moves to XFER.
REQ-023 XFER: READY=1; OE=1 while RD=0; WE=1 for exactly this one cycle if the strobe is WR; next state is HOLD.
REQ-024 HOLD: OE stays high while RD=0, WE=0, READY=1; RD=1 and WR=1 together return the FSM to IDLE.
REQ-025 In ADDR, READY stays 1 until a strobe is seen.
REQ-026 A decode miss sets ERR; the cycle then runs with no CS, OE or WE and zero wait states.
REQ-027 RD=0 and WR=0 together in any state except IDLE sets ERR, forces OE=WE=0, and holds the FSM in its current state until both are released, then goes to IDLE.
REQ-028 ALE=1 in any non-IDLE state aborts the current cycle: a new capture occurs, LOAD pulses, and the FSM goes to ADDR; OE and WE drop the same edge.
REQ-029 The wait counter is 3 bits unsigned and never wraps below 0.
REQ-030 ERR clears only on RESET.

Reset
REQ-031 RESET=1 at a CLK edge puts the FSM in IDLE and forces CS=0, LOAD=0, OE=0, WE=0, READY=1, ERR=0, wait counter=0, and the captured address and IOM registers to 0.
REQ-032 Reset mid-cycle takes priority over ALE and the strobes; no WE pulse is issued in the reset cycle.

Structure
REQ-033 A shared package bus_pkg holds the state enum, the CS index constants, the I/O base constants 12'hFF0 and 12'h1C0, and the 3-bit wait-count type.
REQ-034 The decode logic lives in one combinational sub-module, addr_decode, which maps captured ADDRESS and IOM to CS and a miss signal.

Verification
REQ-035 Memory read: ALE, IOM=0, ADDRESS=20'h00100, then RD=0 -> LOAD one cycle, CS=4'b0001, READY never low, OE=1 until RD=1, then IDLE.
REQ-036 Memory write with waits: ADDRESS=20'h80010, WR=0, WAIT_MEM1=1 -> CS=4'b0010, READY=0 for exactly 1 cycle, WE high for exactly 1 cycle.
REQ-037 I/O read: IOM=1, ADDRESS=20'h0FF04, RD=0 -> CS=4'b0100, READY low for 2 cycles, then OE=1.
REQ-038 Decode miss: IOM=1, ADDRESS=20'h01230, WR=0 -> CS=0, WE never asserted, ERR=1 and still 1 after the cycle ends.
REQ-039 Abort and reset: ALE reasserted during WAIT captures the new address and the FSM returns to ADDR; RESET during XFER gives all outputs their reset values next edge with no WE.
REQ-040 Protocol error: RD=0 and WR=0 together in ADDR -> ERR=1, OE=WE=0, the FSM holds until both are high, then IDLE.
